line_transfer_unit: RTL and testbench
=====================================

// Module: line_transfer_unit
// PURPOSE
//  Memory-side partner of the cache data array. It evicts a full line: one array read, then a
//  4-beat burst write to memory. It fills a line: a 4-beat burst read from memory, with each
//  beat written into the array through the byte write mask as it arrives.
//  Sits between the cache control FSM and the memory/arbiter port.
// PARAMETERS
//  s_offset  5   log2 bytes per line; s_mask = 2**s_offset, s_line = 8*s_mask
//  s_index   4   log2 sets; width of array indices
//  s_beat    64  memory beat width in bits; beats = s_line/s_beat (4 at defaults)
// PORTS
//  clk           in   1         single clock, all state on posedge
//  rst           in   1         reset, asynchronous, active-low
//  req_evict     in   1         start writeback of line at req_index to evict_addr
//  req_fill      in   1         start fill of line at req_index from fill_addr
//  req_index     in   s_index   target set
//  evict_addr    in   32        line-aligned writeback address
//  fill_addr     in   32        line-aligned fill address
//  busy          out  1         high in every state except IDLE
//  done          out  1         one-cycle pulse when whole request completes
//  da_read       out  1         array read strobe
//  da_rindex     out  s_index   array read index
//  da_write_en   out  s_mask    array byte write mask
//  da_windex     out  s_index   array write index
//  da_datain     out  s_line    array write data
//  da_dataout    in   s_line    array read data, valid 1 cycle after da_read
//  mem_addr      out  32        burst base address, held for whole burst
//  mem_read      out  1         burst read request, held until last mem_resp
//  mem_write     out  1         burst write request, held until last mem_resp
//  mem_wdata     out  s_beat    current write beat
//  mem_rdata     in   s_beat    current read beat, valid with mem_resp
//  mem_resp      in   1         one pulse per completed beat
// BEHAVIOUR
//  Reset (rst low, asynchronous): state IDLE, beat counter 0, line buffer 0.
//   All outputs 0: busy, done, da_read, da_write_en, mem_read, mem_write, indices, addr, data.
//  Requests are sampled only in IDLE. req_index, evict_addr and fill_addr are latched at acceptance.
//   Requests raised while busy are ignored; the controller holds a request until done.
//  FSM: IDLE -> EV_RD -> EV_CAP -> EV_BURST -> [FILL_BURST] -> DONE -> IDLE; IDLE -> FILL_BURST.
//  IDLE:       req_evict -> EV_RD. Otherwise req_fill -> FILL_BURST. Both high -> evict, then fill, one done.
//  EV_RD:      da_read=1, da_rindex=latched index, for exactly 1 cycle.
//  EV_CAP:     line buffer <= da_dataout; beat counter <= 0.
//  EV_BURST:   mem_write=1, mem_addr=evict_addr, mem_wdata=buffer[s_beat*cnt +: s_beat].
//   Each mem_resp increments cnt. On the mem_resp with cnt==beats-1: go to FILL_BURST if a fill
//   is pending, else DONE. mem_write drops the cycle after the last mem_resp.
//  FILL_BURST: mem_read=1, mem_addr=fill_addr.
//   In the cycle mem_resp=1: da_windex=latched index; da_write_en has bytes
//   [cnt*s_beat/8 +: s_beat/8] set, all others 0; da_datain places mem_rdata at
//   [s_beat*cnt +: s_beat], other bits 0.
//   da_write_en is combinational from mem_resp and is 0 in any cycle without mem_resp.
//   Last beat (cnt==beats-1) -> DONE.
//  DONE:       done=1 for one cycle; clear pending flags -> IDLE.
//  The beat counter is log2(beats) bits, reset to 0 on entry to each burst; it never wraps
//   mid-burst. mem_resp outside the EV_BURST and FILL_BURST states is ignored.
//  Minimum latency: evict = 2 + beats + 1 cycles; fill = beats + 1 cycles (mem_resp every cycle).
//  Reset asserted mid-burst: the burst is abandoned immediately, with no done.
//   Partially filled array bytes are left as written.
//  Evict+fill on the same index: the line buffer is captured before any fill write. Safe by order.
// STRUCTURE
//  cache_pkg: ltu_state_t enum, localparams s_mask/s_line/beats/beat_bytes, and a beat_mask()
//   function that returns the byte mask for a beat number.
//  Single module; the line buffer and beat counter are inline, with no sub-module.
// TESTING
//  1 Evict idx 3, array line = 256'h{4 beats A,B,C,D}, mem_resp every cycle
//    -> da_read 1 cycle with rindex=3; mem_wdata sequence D0,D1,D2,D3 at evict_addr;
//       done 7 cycles after acceptance.
//  2 Fill idx 5, mem_rdata 64'h11..,22..,33..,44.., mem_resp on cycles 2,5,6,9
//    -> da_write_en = 32'h000000FF, 0000FF00, 00FF0000, FF000000 only on resp cycles;
//       the array line reads back 44..33..22..11.
//  3 req_evict and req_fill both high, same idx 0
//    -> write burst completes with the old data, then the read burst; exactly one done pulse;
//       the array holds the fill data.
//  4 req_fill pulsed while in EV_BURST of an evict-only request
//    -> ignored; no mem_read; done after the write burst.
//  5 rst driven low during beat 2 of a fill
//    -> all outputs 0 asynchronously, next cycle IDLE, no done; beats 0-1 remain in the array.
//  6 Stray mem_resp in IDLE, then a normal fill
//    -> no array write from the stray pulse; the fill still takes exactly 4 beats.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry for the line transfer unit.
package cache_pkg;

  localparam int CP_S_OFFSET   = 5;
  localparam int CP_S_INDEX    = 4;
  localparam int CP_S_BEAT     = 64;
  localparam int CP_S_MASK     = 2 ** CP_S_OFFSET;
  localparam int CP_S_LINE     = 8 * CP_S_MASK;
  localparam int CP_BEATS      = CP_S_LINE / CP_S_BEAT;
  localparam int CP_BEAT_BYTES = CP_S_BEAT / 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EV_RD      = 3'd1,
    ST_EV_CAP     = 3'd2,
    ST_EV_BURST   = 3'd3,
    ST_FILL_BURST = 3'd4,
    ST_DONE       = 3'd5
  } ltu_state_t;

  // Byte-enable mask covering one memory beat within a line.
  function automatic logic [CP_S_MASK-1:0] beat_mask(input int unsigned beat);
    logic [CP_S_MASK-1:0] m;
    m = '0;
    m[beat*CP_BEAT_BYTES +: CP_BEAT_BYTES] = '1;
    return m;
  endfunction

endpackage

// File: rtl/line_transfer_unit.sv
// Line transfer unit: evicts a cache line (array read + burst write) and
// fills a line (burst read, each beat written into the array as it lands).
module line_transfer_unit
  import cache_pkg::*;
#(
  parameter int s_offset = CP_S_OFFSET,
  parameter int s_index  = CP_S_INDEX,
  parameter int s_beat   = CP_S_BEAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_evict,
  input  logic                      req_fill,
  input  logic [s_index-1:0]        req_index,
  input  logic [31:0]               evict_addr,
  input  logic [31:0]               fill_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      da_read,
  output logic [s_index-1:0]        da_rindex,
  output logic [(2**s_offset)-1:0]  da_write_en,
  output logic [s_index-1:0]        da_windex,
  output logic [8*(2**s_offset)-1:0] da_datain,
  input  logic [8*(2**s_offset)-1:0] da_dataout,
  output logic [31:0]               mem_addr,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [s_beat-1:0]         mem_wdata,
  input  logic [s_beat-1:0]         mem_rdata,
  input  logic                      mem_resp
);

  localparam int s_mask     = 2 ** s_offset;
  localparam int s_line     = 8 * s_mask;
  localparam int beats      = s_line / s_beat;
  localparam int beat_bytes = s_beat / 8;
  localparam int cnt_w      = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

  ltu_state_t          state;
  logic [cnt_w-1:0]    cnt;
  logic [s_line-1:0]   lbuf;
  logic [s_index-1:0]  idx_q;
  logic [31:0]         ev_addr_q;
  logic [31:0]         fl_addr_q;
  logic                fill_pend;

  // Control FSM, beat counter and line buffer. Request fields are latched
  // at acceptance so the controller may change them once busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lbuf      <= '0;
      idx_q     <= '0;
      ev_addr_q <= '0;
      fl_addr_q <= '0;
      fill_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_evict || req_fill) begin
            idx_q     <= req_index;
            ev_addr_q <= evict_addr;
            fl_addr_q <= fill_addr;
            cnt       <= '0;
            // Combined request: evict first, fill follows, single done.
            fill_pend <= req_evict && req_fill;
            state     <= req_evict ? ST_EV_RD : ST_FILL_BURST;
          end
        end
        ST_EV_RD: state <= ST_EV_CAP;
        ST_EV_CAP: begin
          // Buffer is captured before any fill write, so evict+fill on the
          // same index writes back the old contents.
          lbuf  <= da_dataout;
          cnt   <= '0;
          state <= ST_EV_BURST;
        end
        ST_EV_BURST: begin
          if (mem_resp) begin
            if (cnt == last_beat) begin
              cnt   <= '0;
              state <= fill_pend ? ST_FILL_BURST : ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FILL_BURST: begin
          if (mem_resp) begin
            if (cnt == last_beat) begin
              cnt   <= '0;
              state <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          fill_pend <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state only (plus mem_resp for array writes), so an
  // asynchronous reset clears them immediately.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    da_read     = (state == ST_EV_RD);
    da_rindex   = da_read ? idx_q : '0;
    mem_write   = (state == ST_EV_BURST);
    mem_read    = (state == ST_FILL_BURST);
    mem_addr    = mem_write ? ev_addr_q : (mem_read ? fl_addr_q : '0);
    mem_wdata   = mem_write ? lbuf[s_beat*cnt +: s_beat] : '0;
    da_write_en = '0;
    da_windex   = '0;
    da_datain   = '0;
    if (mem_read && mem_resp) begin
      da_windex                                  = idx_q;
      da_write_en[beat_bytes*cnt +: beat_bytes]  = '1;
      da_datain[s_beat*cnt +: s_beat]            = mem_rdata;
    end
  end

endmodule

// File: tb/tb_line_transfer_unit.sv
// Directed bench for line_transfer_unit with an array model, a reactive
// memory responder and scoreboard queues for write beats and array writes.
module tb_line_transfer_unit;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_evict, req_fill;
  logic [3:0]   req_index;
  logic [31:0]  evict_addr, fill_addr;
  logic         busy, done, da_read;
  logic [3:0]   da_rindex, da_windex;
  logic [31:0]  da_write_en;
  logic [255:0] da_datain, da_dataout;
  logic [31:0]  mem_addr;
  logic         mem_read, mem_write;
  logic [63:0]  mem_wdata, mem_rdata;
  logic         mem_resp;

  line_transfer_unit dut (
    .clk(clk), .rst(rst), .req_evict(req_evict), .req_fill(req_fill),
    .req_index(req_index), .evict_addr(evict_addr), .fill_addr(fill_addr),
    .busy(busy), .done(done), .da_read(da_read), .da_rindex(da_rindex),
    .da_write_en(da_write_en), .da_windex(da_windex), .da_datain(da_datain),
    .da_dataout(da_dataout), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] mask; logic [255:0] data; logic [3:0] idx; logic [31:0] addr; } wr_exp_t;
  typedef struct { logic [63:0] data; logic [31:0] addr; } wd_exp_t;

  wr_exp_t      exp_wr[$];
  wd_exp_t      exp_wd[$];
  logic [63:0]  fill_q[$];
  wr_exp_t      we_e;
  wd_exp_t      wd_e;
  logic [255:0] arr [16];
  logic         rd_pend = 1'b0;
  logic [3:0]   rd_idx  = '0;
  int vectors = 0, errs = 0;
  int done_cnt = 0, rd_cnt = 0, mr_cnt = 0;
  logic [3:0]   last_rindex = '0;
  int           fbeat = 0;
  logic [3:0]   cur_idx = '0;
  logic [31:0]  cur_faddr = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Array model plus output monitors, all evaluated mid-cycle.
  always @(negedge clk) begin
    da_dataout = rd_pend ? arr[rd_idx] : {4{64'hA5A5_5A5A_DEAD_BEEF}};
    rd_pend    = da_read;
    rd_idx     = da_rindex;
    for (int b = 0; b < 32; b++)
      if (da_write_en[b]) arr[da_windex][8*b +: 8] = da_datain[8*b +: 8];
    if (rst) begin
      if (done) done_cnt++;
      if (da_read) begin rd_cnt++; last_rindex = da_rindex; end
      if (mem_read) mr_cnt++;
      if (mem_write && mem_resp) begin
        if (exp_wd.size() == 0) chk("wd_unexpected", 256'(mem_wdata), 256'(0));
        else begin
          wd_e = exp_wd.pop_front();
          chk("mem_wdata", 256'(mem_wdata), 256'(wd_e.data));
          chk("wr_addr", 256'(mem_addr), 256'(wd_e.addr));
        end
      end
      if (da_write_en != 32'd0) begin
        chk("we_needs_resp", 256'(mem_resp), 256'(1));
        if (exp_wr.size() == 0) chk("we_unexpected", 256'(da_write_en), 256'(0));
        else begin
          we_e = exp_wr.pop_front();
          chk("da_write_en", 256'(da_write_en), 256'(we_e.mask));
          chk("da_datain", da_datain, we_e.data);
          chk("da_windex", 256'(da_windex), 256'(we_e.idx));
          chk("rd_addr", 256'(mem_addr), 256'(we_e.addr));
        end
      end
    end
  end

  // Memory responder for the current cycle; fill beats come from fill_q.
  task automatic drive_mem(input logic r);
    mem_resp  = r && (mem_read || mem_write);
    mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    if (mem_resp && mem_read && fill_q.size() != 0) begin
      mem_rdata = fill_q.pop_front();
      exp_wr.push_back('{32'hFF << (8*fbeat), 256'(mem_rdata) << (64*fbeat), cur_idx, cur_faddr});
      fbeat++;
    end
  endtask

  // Runs a request already driven on the inputs; pat[c] enables mem_resp in cycle c.
  task automatic run(input int maxc, input logic [63:0] pat, input int pulse_c, output int dc);
    dc = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin req_evict = 1'b0; req_fill = 1'b0; end
      if (pulse_c != 0) req_fill = (c == pulse_c);
      if (done && dc < 0) dc = c;
      if (dc > 0 && c == dc + 1) begin
        chk("done_width", 256'(done), 256'(0));
        chk("idle_after_done", 256'(busy), 256'(0));
        break;
      end
      drive_mem(pat[c]);
    end
    mem_resp = 1'b0;
    chk("done_seen", 256'(dc > 0), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line, fline, expl, snap;
    int dc, d0, r0, m0;
    rst = 1'b0; req_evict = 1'b0; req_fill = 1'b0; req_index = '0;
    evict_addr = '0; fill_addr = '0; mem_rdata = '0; mem_resp = 1'b0;
    for (int i = 0; i < 16; i++) arr[i] = {8{32'h1000_0000 + 32'(i)}};
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_da_read", 256'(da_read), 256'(0));
    chk("rst_we", 256'(da_write_en), 256'(0));
    chk("rst_memrw", 256'({mem_read, mem_write}), 256'(0));
    chk("rst_addr", 256'(mem_addr), 256'(0));
    chk("rst_data", da_datain | 256'(mem_wdata), 256'(0));
    chk("rst_idx", 256'({da_rindex, da_windex}), 256'(0));
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;

    // 1: evict idx 3, response every cycle
    line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    arr[3] = line;
    for (int k = 0; k < 4; k++) exp_wd.push_back('{line[64*k +: 64], 32'h0000_1040});
    d0 = done_cnt; r0 = rd_cnt;
    req_evict = 1'b1; req_index = 4'd3; evict_addr = 32'h0000_1040; fill_addr = 32'hFFFF_FFE0;
    run(20, '1, 0, dc);
    chk("t1_latency", 256'(dc), 256'(7));
    chk("t1_done_cnt", 256'(done_cnt - d0), 256'(1));
    chk("t1_rd_cycles", 256'(rd_cnt - r0), 256'(1));
    chk("t1_rindex", 256'(last_rindex), 256'(3));
    chk("t1_wd_drained", 256'(exp_wd.size()), 256'(0));

    // 2: fill idx 5, responses on cycles 2,5,6,9
    fill_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    fbeat = 0; cur_idx = 4'd5; cur_faddr = 32'h0000_2000; d0 = done_cnt;
    req_fill = 1'b1; req_index = 4'd5; fill_addr = 32'h0000_2000; evict_addr = 32'hFFFF_0000;
    run(30, 64'h264, 0, dc);
    chk("t2_latency", 256'(dc), 256'(10));
    chk("t2_done_cnt", 256'(done_cnt - d0), 256'(1));
    expl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    chk("t2_line", arr[5], expl);
    chk("t2_wr_drained", 256'(exp_wr.size()), 256'(0));

    // 3: evict + fill together on idx 0
    line  = {64'h0F0F_0F0F_0F0F_0F03, 64'h0F0F_0F0F_0F0F_0F02,
             64'h0F0F_0F0F_0F0F_0F01, 64'h0F0F_0F0F_0F0F_0F00};
    fline = {64'hF3F3_0000_1234_5678, 64'hF2F2_0000_1234_5678,
             64'hF1F1_0000_1234_5678, 64'hF0F0_0000_1234_5678};
    arr[0] = line;
    for (int k = 0; k < 4; k++) begin
      exp_wd.push_back('{line[64*k +: 64], 32'h0000_3000});
      fill_q.push_back(fline[64*k +: 64]);
    end
    fbeat = 0; cur_idx = 4'd0; cur_faddr = 32'h0000_4000; d0 = done_cnt;
    req_evict = 1'b1; req_fill = 1'b1; req_index = 4'd0;
    evict_addr = 32'h0000_3000; fill_addr = 32'h0000_4000;
    run(30, '1, 0, dc);
    chk("t3_latency", 256'(dc), 256'(11));
    chk("t3_done_cnt", 256'(done_cnt - d0), 256'(1));
    chk("t3_line", arr[0], fline);
    chk("t3_drained", 256'(exp_wd.size() + exp_wr.size()), 256'(0));

    // 4: fill request pulsed during an evict burst is ignored
    line = {64'h4444_0000_0000_0002, 64'h3333_0000_0000_0002,
            64'h2222_0000_0000_0002, 64'h1111_0000_0000_0002};
    arr[2] = line;
    for (int k = 0; k < 4; k++) exp_wd.push_back('{line[64*k +: 64], 32'h0000_5000});
    d0 = done_cnt; m0 = mr_cnt;
    req_evict = 1'b1; req_index = 4'd2; evict_addr = 32'h0000_5000; fill_addr = 32'h0000_6000;
    run(20, '1, 4, dc);
    req_fill = 1'b0;
    chk("t4_latency", 256'(dc), 256'(7));
    chk("t4_no_mem_read", 256'(mr_cnt - m0), 256'(0));
    chk("t4_done_cnt", 256'(done_cnt - d0), 256'(1));
    chk("t4_wd_drained", 256'(exp_wd.size()), 256'(0));

    // 5: reset during beat 2 of a fill
    line  = arr[7];
    fill_q = '{64'h5555_0000_0000_0000, 64'h6666_0000_0000_0001,
               64'h7777_0000_0000_0002, 64'h8888_0000_0000_0003};
    fbeat = 0; cur_idx = 4'd7; cur_faddr = 32'h0000_7000; d0 = done_cnt;
    req_fill = 1'b1; req_index = 4'd7; fill_addr = 32'h0000_7000;
    @(posedge clk); #1; req_fill = 1'b0; drive_mem(1'b1);
    @(posedge clk); #1; drive_mem(1'b1);
    @(posedge clk); #1; drive_mem(1'b0);
    chk("t5_busy_before", 256'(busy), 256'(1));
    rst = 1'b0; #1;
    chk("t5_busy_async", 256'(busy), 256'(0));
    chk("t5_memrd_async", 256'(mem_read), 256'(0));
    chk("t5_addr_async", 256'(mem_addr), 256'(0));
    chk("t5_done_async", 256'(done), 256'(0));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", 256'(busy), 256'(0));
    chk("t5_no_done", 256'(done_cnt - d0), 256'(0));
    expl = {line[255:128], 64'h6666_0000_0000_0001, 64'h5555_0000_0000_0000};
    chk("t5_partial_line", arr[7], expl);
    fill_q.delete();

    // 6: stray mem_resp in IDLE, then a normal fill
    snap = arr[0];
    mem_resp = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("t6_stray_we", 256'(da_write_en), 256'(0));
    @(posedge clk); #1; mem_resp = 1'b0;
    chk("t6_stray_idle", 256'(busy), 256'(0));
    chk("t6_arr_untouched", arr[0], snap);
    fline = {64'hC3C3_C3C3_0000_0009, 64'hC2C2_C2C2_0000_0009,
             64'hC1C1_C1C1_0000_0009, 64'hC0C0_C0C0_0000_0009};
    for (int k = 0; k < 4; k++) fill_q.push_back(fline[64*k +: 64]);
    fbeat = 0; cur_idx = 4'd9; cur_faddr = 32'h0000_9000; d0 = done_cnt;
    req_fill = 1'b1; req_index = 4'd9; fill_addr = 32'h0000_9000;
    run(20, '1, 0, dc);
    chk("t6_latency", 256'(dc), 256'(5));
    chk("t6_beats", 256'(fbeat), 256'(4));
    chk("t6_line", arr[9], fline);
    chk("t6_done_cnt", 256'(done_cnt - d0), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
